// File: rtl/la_pkg.sv
// la_pkg: shared FSM state type and trigger mode codes for the logic-analyser capture core.
package la_pkg;
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} la_state_e;
  localparam logic [1:0] LA_LEVEL = 2'b00;
  localparam logic [1:0] LA_RISE  = 2'b01;
  localparam logic [1:0] LA_FALL  = 2'b10;
  localparam logic [1:0] LA_ANY   = 2'b11;
endpackage

// File: rtl/la_sample_ram.sv
// la_sample_ram: simple dual-port sample buffer, DATA_W x DEPTH, one-clock registered read.
//   clk   sample clock
//   rst_n asynchronous active-low reset of the read register only
//   we/waddr/wdata  write port
//   re/raddr        read port; rdata updates only when re is high, otherwise holds
module la_sample_ram #(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/la_capture_core.sv
// la_capture_core: logic-analyser capture of a probe bus into a circular buffer around a trigger.
//   clk_i, rst_n_i           clock, asynchronous active-low reset
//   data_i                   probe samples written every capturing cycle
//   trig_i/trig_mask_i/trig_mode_i  trigger inputs, participation mask, mode (level/rise/fall/any)
//   pretrig_i, arm_i         pre-trigger sample count and start pulse (both latched on arm)
//   rd_req_i -> rd_data_o/rd_valid_o/rd_last_o  in-order readout, oldest sample first
//   armed_o/triggered_o/done_o  status; trig_addr_o  buffer address of the trigger sample
module la_capture_core
  import la_pkg::*;
#(
  parameter int DATA_W = 6,
  parameter int TRIG_W = 1,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [TRIG_W-1:0] trig_i,
  input  logic [TRIG_W-1:0] trig_mask_i,
  input  logic [1:0]        trig_mode_i,
  input  logic [ADDR_W-1:0] pretrig_i,
  input  logic              arm_i,
  input  logic              rd_req_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              rd_last_o,
  output logic              armed_o,
  output logic              triggered_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] trig_addr_o
);
  la_state_e state, state_nx;
  logic [ADDR_W-1:0] waddr, cnt, pre_len;
  logic [TRIG_W-1:0] mask, prev, hit;
  logic [1:0] mode;
  logic [ADDR_W:0] rd_cnt;
  logic trig_fire, pre_end, post_end, rd_go, wr_en;
  // pretrig_i is ADDR_W bits wide, so it can never exceed DEPTH-1 and needs no clamp.
  // The post-trigger length DEPTH-1-pre_len is simply ~pre_len in ADDR_W bits.
  always_comb begin
    hit = mask & (mode == LA_LEVEL ? trig_i :
                  mode == LA_RISE  ? trig_i & ~prev :
                  mode == LA_FALL  ? ~trig_i & prev : trig_i ^ prev);
    trig_fire = state == S_WAIT && (mask == '0 || |hit);
    pre_end   = cnt == pre_len - 1'b1;
    post_end  = cnt == ~pre_len - 1'b1;
    wr_en     = !arm_i && (state == S_PRE || state == S_WAIT || state == S_POST);
    rd_go     = state == S_DONE && rd_req_i && rd_cnt != (ADDR_W+1)'(DEPTH);
  end
  always_comb begin
    state_nx = state;
    if (arm_i) state_nx = pretrig_i == '0 ? S_WAIT : S_PRE;
    else if (state == S_PRE && pre_end) state_nx = S_WAIT;
    else if (trig_fire) state_nx = ~pre_len == '0 ? S_DONE : S_POST;
    else if (state == S_POST && post_end) state_nx = S_DONE;
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) state <= S_IDLE;
    else state <= state_nx;
  // After the final write waddr points one past the newest sample, which is the oldest,
  // so in DONE the same pointer doubles as the read pointer.
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      waddr <= '0;
      cnt <= '0;
      pre_len <= '0;
      mask <= '0;
      mode <= LA_LEVEL;
      prev <= '0;
      rd_cnt <= '0;
      trig_addr_o <= '0;
      rd_valid_o <= 1'b0;
      rd_last_o <= 1'b0;
    end else begin
      prev <= trig_i;
      rd_valid_o <= rd_go;
      rd_last_o <= rd_go && rd_cnt == (ADDR_W+1)'(DEPTH - 1);
      if (arm_i) begin
        waddr <= '0;
        cnt <= '0;
        pre_len <= pretrig_i;
        mask <= trig_mask_i;
        mode <= trig_mode_i;
        rd_cnt <= '0;
        trig_addr_o <= '0;
      end else begin
        if (wr_en) begin
          waddr <= waddr + 1'b1;
          cnt <= state_nx != state ? '0 : cnt + 1'b1;
        end
        if (trig_fire) trig_addr_o <= waddr;
        if (rd_go) begin
          waddr <= waddr + 1'b1;
          rd_cnt <= rd_cnt + 1'b1;
        end
      end
    end
  assign armed_o     = state == S_PRE || state == S_WAIT;
  assign triggered_o = state == S_POST;
  assign done_o      = state == S_DONE;
  la_sample_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk(clk_i),
    .rst_n(rst_n_i),
    .we(wr_en),
    .waddr(waddr),
    .wdata(data_i),
    .re(rd_go),
    .raddr(waddr),
    .rdata(rd_data_o)
  );
endmodule

// File: tb/tb_la_capture_core.sv
// tb_la_capture_core: directed scoreboard bench for la_capture_core (DEPTH=16, TRIG_W=4, DATA_W=8).
module tb_la_capture_core;
  import la_pkg::*;
  localparam int DW = 8, TW = 4, DEPTH = 16, AW = 4;
  logic clk = 0, rst_n = 0;
  logic [DW-1:0] data_i = '0, rd_data_o;
  logic [TW-1:0] trig_i = '0, trig_mask_i = '0;
  logic [1:0] trig_mode_i = '0;
  logic [AW-1:0] pretrig_i = '0, trig_addr_o;
  logic arm_i = 0, rd_req_i = 0;
  logic rd_valid_o, rd_last_o, armed_o, triggered_o, done_o;
  int n_cmp = 0, n_bad = 0, smp = 0;
  logic [DW:0] exp_q[$];

  la_capture_core #(.DATA_W(DW), .TRIG_W(TW), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(data_i), .trig_i(trig_i),
    .trig_mask_i(trig_mask_i), .trig_mode_i(trig_mode_i), .pretrig_i(pretrig_i),
    .arm_i(arm_i), .rd_req_i(rd_req_i), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
    .rd_last_o(rd_last_o), .armed_o(armed_o), .triggered_o(triggered_o), .done_o(done_o),
    .trig_addr_o(trig_addr_o)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  always @(negedge clk)
    if (rst_n && rd_valid_o) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rd_unexpected: got data=%0d expected no rd_valid", rd_data_o);
      end else chk("rd_sample{last,data}", {rd_last_o, rd_data_o}, exp_q.pop_front());
    end

  task automatic tick(int n);
    repeat (n) begin
      @(negedge clk);
      smp++;
      data_i = DW'(smp);
    end
  endtask

  task automatic arm_it(logic [AW-1:0] p, logic [TW-1:0] m, logic [1:0] md);
    @(negedge clk);
    arm_i = 1;
    pretrig_i = p;
    trig_mask_i = m;
    trig_mode_i = md;
    @(negedge clk);
    arm_i = 0;
    smp = 0;
    data_i = '0;
  endtask

  task automatic expect_range(int first, int n);
    for (int i = 0; i < n; i++) exp_q.push_back({i == n - 1, DW'(first + i)});
  endtask

  task automatic reads(int n);
    repeat (n) begin
      @(negedge clk);
      rd_req_i = 1;
    end
    @(negedge clk);
    rd_req_i = 0;
  endtask

  task automatic flags(string nm, logic a, logic t, logic d);
    chk(nm, {armed_o, triggered_o, done_o}, {a, t, d});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", {armed_o, triggered_o, done_o, rd_valid_o, rd_last_o}, 0);
    chk("reset_rd_data", rd_data_o, 0);
    chk("reset_trig_addr", trig_addr_o, 0);
    rst_n = 1;
    reads(2);
    flags("idle_flags", 0, 0, 0);
    // rising edge at sample 20, 4 pre-trigger samples
    arm_it(4, 4'b0001, LA_RISE);
    tick(20);
    flags("t1_waiting", 1, 0, 0);
    trig_i = 4'b0001;
    tick(1);
    flags("t1_post", 0, 1, 0);
    chk("t1_trig_addr", trig_addr_o, 4);
    tick(10);
    flags("t1_post_last", 0, 1, 0);
    tick(1);
    flags("t1_done", 0, 0, 1);
    expect_range(16, 16);
    reads(16);
    reads(2);
    repeat (2) @(negedge clk);
    chk("t1_all_read", exp_q.size(), 0);
    chk("t1_rd_hold", rd_data_o, 31);
    // level trigger already high, no pre-trigger window
    arm_it(0, 4'b0001, LA_LEVEL);
    flags("t2_armed", 1, 0, 0);
    tick(1);
    flags("t2_post", 0, 1, 0);
    chk("t2_trig_addr", trig_addr_o, 0);
    tick(15);
    flags("t2_done", 0, 0, 1);
    exp_q.push_back({1'b0, 8'd0});
    exp_q.push_back({1'b0, 8'd1});
    reads(2);
    // maximum pre-trigger window: trigger goes straight to DONE
    trig_i = 4'b0000;
    arm_it(15, 4'b0001, LA_RISE);
    tick(15);
    flags("t3_wait", 1, 0, 0);
    tick(10);
    trig_i = 4'b0001;
    tick(1);
    flags("t3_done", 0, 0, 1);
    chk("t3_trig_addr", trig_addr_o, 9);
    expect_range(10, 16);
    reads(16);
    // masked falling trigger on bit 2, other bits toggling
    trig_i = 4'b0100;
    arm_it(4, 4'b0100, LA_FALL);
    tick(10);
    trig_i = 4'b0111;
    tick(5);
    trig_i = 4'b0101;
    tick(5);
    trig_i = 4'b1101;
    tick(10);
    flags("t4_no_false_trig", 1, 0, 0);
    trig_i = 4'b1001;
    tick(1);
    flags("t4_post", 0, 1, 0);
    chk("t4_trig_addr", trig_addr_o, 14);
    tick(11);
    flags("t4_done", 0, 0, 1);
    expect_range(26, 16);
    reads(16);
    // edge during PRE ignored; re-arm during POST; reset during POST
    trig_i = 4'b0000;
    arm_it(8, 4'b0001, LA_RISE);
    tick(3);
    trig_i = 4'b0001;
    tick(9);
    flags("t5_pre_edge_ignored", 1, 0, 0);
    trig_i = 4'b0000;
    tick(2);
    trig_i = 4'b0001;
    tick(1);
    flags("t5_post", 0, 1, 0);
    chk("t5_trig_addr", trig_addr_o, 14);
    tick(3);
    arm_it(2, 4'b0001, LA_RISE);
    flags("t5_rearm", 1, 0, 0);
    tick(2);
    trig_i = 4'b0000;
    tick(3);
    trig_i = 4'b0001;
    tick(1);
    flags("t5_post2", 0, 1, 0);
    chk("t5_trig_addr2", trig_addr_o, 5);
    tick(3);
    rst_n = 0;
    #1;
    chk("t5_rst_flags", {armed_o, triggered_o, done_o, rd_valid_o, rd_last_o}, 0);
    chk("t5_rst_trig_addr", trig_addr_o, 0);
    @(negedge clk);
    rst_n = 1;
    reads(3);
    flags("t5_after_rst", 0, 0, 0);
    // zero mask triggers immediately; reset during readout
    arm_it(0, 4'b0000, LA_LEVEL);
    tick(1);
    flags("t6_mask0_trig", 0, 1, 0);
    chk("t6_trig_addr", trig_addr_o, 0);
    tick(15);
    flags("t6_done", 0, 0, 1);
    exp_q.push_back({1'b0, 8'd0});
    exp_q.push_back({1'b0, 8'd1});
    exp_q.push_back({1'b0, 8'd2});
    repeat (3) begin
      @(negedge clk);
      rd_req_i = 1;
    end
    @(negedge clk);
    rd_req_i = 0;
    #2;
    rst_n = 0;
    #1;
    chk("t6_rst_flags", {armed_o, triggered_o, done_o, rd_valid_o, rd_last_o}, 0);
    chk("t6_rst_rd_data", rd_data_o, 0);
    @(negedge clk);
    rst_n = 1;
    reads(3);
    flags("t6_after_rst", 0, 0, 0);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
